vector_lane_fifo: RTL and testbench
===================================

Name: vector_lane_fifo

Overview:
- Parametrised synchronous FIFO replacing the fixed 512x32 load/store FIFO macros inside each vector lane.
- Width, depth, almost-full/almost-empty thresholds and read mode (standard or first-word-fall-through) are all parameters.
- Status outputs keep the existing macro's set: empty, full, almost flags, read/write counts, error flags.
- Adds an occupancy count and sticky error flags, so lane control can size bursts without a read-modify guess.

Parameters:
DATA_WIDTH, 32, data word width in bits
DEPTH, 512, number of entries; power of two, >= 4
ALMOST_FULL_OFFSET, 16, almostfull_o asserts when occupancy >= DEPTH - ALMOST_FULL_OFFSET; range 1..DEPTH-1
ALMOST_EMPTY_OFFSET, 16, almostempty_o asserts when occupancy <= ALMOST_EMPTY_OFFSET; range 1..DEPTH-1
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word-fall-through
AW, $clog2(DEPTH), derived pointer width; not overridable

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
wr_en_i  in  1  write request
din_i  in  DATA_WIDTH  write data
rd_en_i  in  1  read (pop) request
dout_o  out  DATA_WIDTH  read data
empty_o  out  1  occupancy == 0
full_o  out  1  occupancy == DEPTH
almostempty_o  out  1  see ALMOST_EMPTY_OFFSET
almostfull_o  out  1  see ALMOST_FULL_OFFSET
count_o  out  AW+1  occupancy, 0..DEPTH
rdcount_o  out  AW  read pointer
wrcount_o  out  AW  write pointer
rderr_o  out  1  one-cycle pulse: rejected read
wrerr_o  out  1  one-cycle pulse: rejected write
err_sticky_o  out  2  {wr, rd} sticky error bits; cleared only by reset

Behaviour:
- Reset, synchronous, evaluated at the clock edge:
  - Pointers and count_o = 0.
  - empty_o = 1, almostempty_o = 1.
  - full_o = 0, almostfull_o = 0.
  - rderr_o, wrerr_o and err_sticky_o = 0.
  - dout_o = 0 in standard mode.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all data and overrides any same-cycle rd/wr.
- Write acceptance: write accepted iff wr_en_i && !full_o. The full test uses the pre-edge full_o, so a same-cycle read does NOT free space for the write.
- On accepted write:
  - mem[wrcount_o] <= din_i.
  - wrcount_o increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read acceptance: read accepted iff rd_en_i && !empty_o. The empty test uses the pre-edge empty_o, so a same-cycle write does NOT make data readable.
- On accepted read: rdcount_o increments modulo DEPTH.
- Occupancy update: count_o next = count + accepted_wr - accepted_rd.
  - Simultaneous accepted read and write leaves count unchanged; both pointers advance.
- Flags: all flags are registered, derived from the next count, and valid the cycle after the operation.
  - full_o = (count == DEPTH).
  - empty_o = (count == 0).
  - Almost flags use the offset parameters.
  - Flags never glitch between edges.
- Rejected write (wr_en_i && full_o): no state change except error reporting.
  - wrerr_o = 1 for exactly the next cycle.
  - err_sticky_o[1] sets.
- Rejected read (rd_en_i && empty_o): no state change except error reporting.
  - rderr_o = 1 for exactly the next cycle.
  - err_sticky_o[0] sets.
  - In standard mode, dout_o holds its previous value.
- FWFT = 0 (standard mode):
  - dout_o is registered; it loads mem[rdcount_o] on an accepted read.
  - Data is visible the cycle after the rd_en_i edge (latency 1).
  - dout_o holds its value otherwise.
- FWFT = 1:
  - dout_o = mem[rdcount_o], combinational read of an LUT-RAM style array.
  - dout_o is valid whenever empty_o = 0.
  - rd_en_i pops the displayed word at the edge.
  - After a write into an empty FIFO, the word appears on dout_o once empty_o drops, one cycle after the write edge.
- Pointer wrap: full/empty are resolved by count_o, never by pointer equality alone.
- Parameter check: an elaboration-time assertion fails if DEPTH is not a power of two, or if either offset is outside 1..DEPTH-1.

Test Plan:
- Reset then fill (DEPTH=512, offsets 16), writing 0..511:
  - almostfull_o rises the cycle after the 496th write.
  - full_o rises after the 512th write.
  - count_o = 512, wrcount_o = 0 (wrapped).
- Write 0xDEADBEEF while full: wrerr_o high for exactly 1 cycle, err_sticky_o = 2'b10, count_o stays 512. Then drain, standard mode:
  - dout_o sequence 0..511, each 1 cycle after its rd_en_i.
  - almostempty_o rises when count_o reaches 16.
  - empty_o rises after the last read.
- Read while empty: rderr_o is a 1-cycle pulse, err_sticky_o = 2'b01, dout_o unchanged. Then simultaneous rd+wr while empty: write accepted, read rejected, count_o = 1, rderr_o pulses.
- Simultaneous rd+wr at count 5 for 600 cycles:
  - count_o stays 5.
  - Data order preserved across pointer wrap.
  - No error pulses.
- Simultaneous rd+wr while full: read accepted, write rejected (wrerr_o pulses), count_o = DEPTH-1.
- FWFT=1, DEPTH=16, offsets 2:
  - Write 0xA5 to empty FIFO: dout_o = 0xA5 with empty_o = 0 one cycle later.
  - rd_en_i pops it: empty_o = 1 next cycle.
- Reset asserted with count 7 and rd_en_i/wr_en_i both high: next cycle count_o = 0, empty_o = 1, err_sticky_o = 0, pointers = 0.

Source files
------------

// File: rtl/vector_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vector_lane_fifo
// Purpose  : Parametrised synchronous FIFO for vector-lane load/store
//            buffering. The read mode is selectable: standard (registered
//            read, one-cycle latency) or first-word-fall-through.
//            All status flags are registered and change only at the clock
//            edge. Occupancy is tracked by an explicit counter, so a full
//            FIFO and an empty FIFO are never confused when the pointers
//            are equal.
//
// Ports    : clk            clock, rising edge
//            reset          synchronous active-high reset
//            wr_en_i        write request
//            din_i          write data
//            rd_en_i        read (pop) request
//            dout_o         read data
//            empty_o        occupancy == 0
//            full_o         occupancy == DEPTH
//            almostempty_o  occupancy <= ALMOST_EMPTY_OFFSET
//            almostfull_o   occupancy >= DEPTH - ALMOST_FULL_OFFSET
//            count_o        occupancy, 0..DEPTH
//            rdcount_o      read pointer
//            wrcount_o      write pointer
//            rderr_o        one-cycle pulse after a rejected read
//            wrerr_o        one-cycle pulse after a rejected write
//            err_sticky_o   {wr, rd} sticky error bits, cleared by reset
//
// Revision : 1.0 - initial release
// ============================================================================
module vector_lane_fifo #(
    parameter int DATA_WIDTH          = 32,
    parameter int DEPTH               = 512,
    parameter int ALMOST_FULL_OFFSET  = 16,
    parameter int ALMOST_EMPTY_OFFSET = 16,
    parameter int FWFT                = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [DATA_WIDTH-1:0]      din_i,
    input  logic                       rd_en_i,
    output logic [DATA_WIDTH-1:0]      dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almostempty_o,
    output logic                       almostfull_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH)-1:0]   rdcount_o,
    output logic [$clog2(DEPTH)-1:0]   wrcount_o,
    output logic                       rderr_o,
    output logic                       wrerr_o,
    output logic [1:0]                 err_sticky_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_AF_LEVEL = (c_AW+1)'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [c_AW:0]   c_AE_LEVEL = (c_AW+1)'(ALMOST_EMPTY_OFFSET);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    localparam bit c_DEPTH_OK = (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0);
    localparam bit c_AF_OK    = (ALMOST_FULL_OFFSET  >= 1) && (ALMOST_FULL_OFFSET  <= DEPTH - 1);
    localparam bit c_AE_OK    = (ALMOST_EMPTY_OFFSET >= 1) && (ALMOST_EMPTY_OFFSET <= DEPTH - 1);

    if (!(c_DEPTH_OK && c_AF_OK && c_AE_OK)) begin : g_param_check
        $error("vector_lane_fifo: DEPTH must be a power of two >= 4 and offsets within 1..DEPTH-1");
    end

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_rderr;
    logic                  r_wrerr;
    logic [1:0]            r_sticky;

    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [c_AW:0]         w_count_next;

    // Acceptance is judged on the registered (pre-edge) flags only: a
    // same-cycle read never frees room for a write into a full FIFO, and a
    // same-cycle write never makes data readable from an empty one.
    assign w_wr_accept = wr_en_i & ~r_full;
    assign w_rd_accept = rd_en_i & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, flags and error reporting
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_rderr        <= 1'b0;
            r_wrerr        <= 1'b0;
            r_sticky       <= 2'b00;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            r_count        <= w_count_next;

            // Flags are computed from the next occupancy so that they are
            // correct in the cycle immediately following the operation.
            r_empty        <= (w_count_next == '0);
            r_full         <= (w_count_next == c_DEPTH);
            r_almost_empty <= (w_count_next <= c_AE_LEVEL);
            r_almost_full  <= (w_count_next >= c_AF_LEVEL);

            r_wrerr        <= wr_en_i & r_full;
            r_rderr        <= rd_en_i & r_empty;
            r_sticky       <= r_sticky | {wr_en_i & r_full, rd_en_i & r_empty};
        end
    end

    // Memory has no reset; reset still blocks the write so that a
    // reset cycle leaves nothing behind that could be mistaken for data.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_accept) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    if (FWFT != 0) begin : g_fwft
        // Head-of-queue word is always presented; it is meaningful whenever
        // empty_o is low, and rd_en_i simply advances past it.
        assign dout_o = r_mem[r_rd_ptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_dout;

        // Registered read: loads only on an accepted read and otherwise
        // holds, including across rejected reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_dout <= '0;
            end else if (w_rd_accept) begin
                r_dout <= r_mem[r_rd_ptr];
            end
        end

        assign dout_o = r_dout;
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign empty_o       = r_empty;
    assign full_o        = r_full;
    assign almostempty_o = r_almost_empty;
    assign almostfull_o  = r_almost_full;
    assign count_o       = r_count;
    assign rdcount_o     = r_rd_ptr;
    assign wrcount_o     = r_wr_ptr;
    assign rderr_o       = r_rderr;
    assign wrerr_o       = r_wrerr;
    assign err_sticky_o  = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_vector_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_lane_fifo
// Purpose  : Self-checking bench for vector_lane_fifo. Instance A is the
//            standard-read 512-entry configuration, instance B is a
//            16-entry first-word-fall-through configuration. A queue model
//            of each FIFO is checked against the DUT on every falling
//            edge, and directed literal expectations pin key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_lane_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [31:0] din [2];

    // Instance A outputs
    logic [31:0] dout_a;
    logic        empty_a, full_a, ae_a, af_a, rderr_a, wrerr_a;
    logic [9:0]  cnt_a;
    logic [8:0]  rdc_a, wrc_a;
    logic [1:0]  st_a;

    // Instance B outputs
    logic [31:0] dout_b;
    logic        empty_b, full_b, ae_b, af_b, rderr_b, wrerr_b;
    logic [4:0]  cnt_b;
    logic [3:0]  rdc_b, wrc_b;
    logic [1:0]  st_b;

    vector_lane_fifo #(
        .DATA_WIDTH(32), .DEPTH(512), .ALMOST_FULL_OFFSET(16),
        .ALMOST_EMPTY_OFFSET(16), .FWFT(0)
    ) u_a (
        .clk(clk), .reset(reset), .wr_en_i(wr[0]), .din_i(din[0]), .rd_en_i(rd[0]),
        .dout_o(dout_a), .empty_o(empty_a), .full_o(full_a),
        .almostempty_o(ae_a), .almostfull_o(af_a), .count_o(cnt_a),
        .rdcount_o(rdc_a), .wrcount_o(wrc_a), .rderr_o(rderr_a),
        .wrerr_o(wrerr_a), .err_sticky_o(st_a)
    );

    vector_lane_fifo #(
        .DATA_WIDTH(32), .DEPTH(16), .ALMOST_FULL_OFFSET(2),
        .ALMOST_EMPTY_OFFSET(2), .FWFT(1)
    ) u_b (
        .clk(clk), .reset(reset), .wr_en_i(wr[1]), .din_i(din[1]), .rd_en_i(rd[1]),
        .dout_o(dout_b), .empty_o(empty_b), .full_o(full_b),
        .almostempty_o(ae_b), .almostfull_o(af_b), .count_o(cnt_b),
        .rdcount_o(rdc_b), .wrcount_o(wrc_b), .rderr_o(rderr_b),
        .wrerr_o(wrerr_b), .err_sticky_o(st_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s : got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a plain queue per instance
    // ------------------------------------------------------------------------
    int          dep  [2] = '{512, 16};
    int          afo  [2] = '{16, 2};
    int          aeo  [2] = '{16, 2};
    bit          fw   [2] = '{1'b0, 1'b1};
    logic [31:0] q    [2][$];
    int          wp   [2];
    int          rp   [2];
    logic        merr_r [2];
    logic        merr_w [2];
    logic [1:0]  mst  [2];
    logic [31:0] md   [2];
    bit          live = 1'b0;

    always @(posedge clk) begin
        int n;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                q[k].delete();
                wp[k] = 0; rp[k] = 0;
                merr_r[k] = 1'b0; merr_w[k] = 1'b0;
                mst[k] = 2'b00; md[k] = 32'h0;
                live = 1'b1;
            end else if (live) begin
                n = q[k].size();
                merr_w[k] = wr[k] && (n == dep[k]);
                merr_r[k] = rd[k] && (n == 0);
                if (rd[k] && n > 0) begin
                    md[k] = q[k].pop_front();
                    rp[k] = (rp[k] + 1) % dep[k];
                end
                if (wr[k] && n < dep[k]) begin
                    q[k].push_back(din[k]);
                    wp[k] = (wp[k] + 1) % dep[k];
                end
                mst[k] = mst[k] | {merr_w[k], merr_r[k]};
            end
        end
    end

    task automatic cmp_inst(input string nm, input int k, input logic [31:0] d,
                            input logic e, input logic f, input logic ae, input logic af,
                            input logic [31:0] c, input logic [31:0] rc, input logic [31:0] wc,
                            input logic re, input logic we, input logic [1:0] st);
        int n;
        n = q[k].size();
        chk({nm, " empty"},   e,  (n == 0));
        chk({nm, " full"},    f,  (n == dep[k]));
        chk({nm, " aempty"},  ae, (n <= aeo[k]));
        chk({nm, " afull"},   af, (n >= dep[k] - afo[k]));
        chk({nm, " count"},   c,  n);
        chk({nm, " rdcount"}, rc, rp[k]);
        chk({nm, " wrcount"}, wc, wp[k]);
        chk({nm, " rderr"},   re, merr_r[k]);
        chk({nm, " wrerr"},   we, merr_w[k]);
        chk({nm, " sticky"},  st, mst[k]);
        if (!fw[k])      chk({nm, " dout"}, d, md[k]);
        else if (n > 0)  chk({nm, " dout"}, d, q[k][0]);
    endtask

    always @(negedge clk) begin
        if (live) begin
            cmp_inst("A", 0, dout_a, empty_a, full_a, ae_a, af_a, 32'(cnt_a),
                     32'(rdc_a), 32'(wrc_a), rderr_a, wrerr_a, st_a);
            cmp_inst("B", 1, dout_b, empty_b, full_b, ae_b, af_b, 32'(cnt_b),
                     32'(rdc_b), 32'(wrc_b), rderr_b, wrerr_b, st_b);
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    task automatic step(input int k, input logic w, input logic [31:0] d, input logic r);
        wr[k] = w; rd[k] = r; din[k] = d;
        @(posedge clk); #1;
        wr[k] = 1'b0; rd[k] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr = 2'b00; rd = 2'b00; din[0] = 32'h0; din[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst count",  32'(cnt_a), 0);
        chk("rst empty",  empty_a, 1);
        chk("rst aempty", ae_a, 1);
        chk("rst full",   full_a, 0);
        chk("rst afull",  af_a, 0);
        chk("rst dout",   dout_a, 0);
        chk("rst sticky", 32'(st_a), 0);
        chk("rst wrcnt",  32'(wrc_a), 0);

        // Fill 0..511
        for (int i = 0; i < 512; i++) begin
            step(0, 1'b1, i, 1'b0);
            if (i == 494) chk("afull at 495", af_a, 0);
            if (i == 495) chk("afull at 496", af_a, 1);
            if (i == 510) chk("full at 511", full_a, 0);
        end
        chk("full at 512",  full_a, 1);
        chk("count 512",    32'(cnt_a), 512);
        chk("wrcnt wrap",   32'(wrc_a), 0);

        // Write while full
        step(0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("wrerr pulse",  wrerr_a, 1);
        chk("sticky wr",    32'(st_a), 2);
        chk("count held",   32'(cnt_a), 512);
        step(0, 1'b0, 0, 1'b0);
        chk("wrerr end",    wrerr_a, 0);

        // Simultaneous rd+wr while full: read wins, write rejected
        step(0, 1'b1, 32'h12345678, 1'b1);
        chk("full rw wrerr", wrerr_a, 1);
        chk("full rw count", 32'(cnt_a), 511);
        chk("full rw dout",  dout_a, 0);

        // Drain the rest
        for (int i = 1; i < 512; i++) begin
            step(0, 1'b0, 0, 1'b1);
            chk("drain dout", dout_a, i);
            if (i == 494) chk("aempty at 17", ae_a, 0);
            if (i == 495) begin
                chk("aempty at 16", ae_a, 1);
                chk("count 16", 32'(cnt_a), 16);
            end
            if (i == 510) chk("empty at 1", empty_a, 0);
        end
        chk("empty at 0", empty_a, 1);

        // Read while empty, sticky write bit still set
        step(0, 1'b0, 0, 1'b1);
        chk("rderr pulse",  rderr_a, 1);
        chk("dout held",    dout_a, 511);
        chk("sticky both",  32'(st_a), 3);
        step(0, 1'b0, 0, 1'b0);
        chk("rderr end",    rderr_a, 0);

        // Reset, then read while empty
        reset = 1'b1;
        step(0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        step(0, 1'b0, 0, 1'b1);
        chk("rderr2 pulse", rderr_a, 1);
        chk("sticky rd",    32'(st_a), 1);
        chk("dout held0",   dout_a, 0);

        // rd+wr while empty: write accepted, read rejected
        step(0, 1'b1, 32'h55, 1'b1);
        chk("empty rw count", 32'(cnt_a), 1);
        chk("empty rw rderr", rderr_a, 1);

        for (int i = 0; i < 4; i++) step(0, 1'b1, 32'h100 + i, 1'b0);
        chk("count 5", 32'(cnt_a), 5);

        // Steady state rd+wr across pointer wrap
        for (int i = 0; i < 600; i++) step(0, 1'b1, 32'h1000 + i, 1'b1);
        chk("steady count", 32'(cnt_a), 5);
        chk("steady dout",  dout_a, 32'h1000 + 594);

        step(0, 1'b1, 32'h2000, 1'b0);
        step(0, 1'b1, 32'h2001, 1'b0);
        chk("count 7", 32'(cnt_a), 7);

        // Reset overrides simultaneous rd/wr
        reset = 1'b1; wr[0] = 1'b1; rd[0] = 1'b1; din[0] = 32'h3000;
        @(posedge clk); #1;
        reset = 1'b0; wr[0] = 1'b0; rd[0] = 1'b0;
        chk("rst2 count",  32'(cnt_a), 0);
        chk("rst2 empty",  empty_a, 1);
        chk("rst2 sticky", 32'(st_a), 0);
        chk("rst2 rdcnt",  32'(rdc_a), 0);
        chk("rst2 wrcnt",  32'(wrc_a), 0);

        // FWFT instance
        step(1, 1'b1, 32'hA5, 1'b0);
        chk("fwft dout",  dout_b, 32'hA5);
        chk("fwft empty", empty_b, 0);
        step(1, 1'b0, 0, 1'b1);
        chk("fwft pop empty", empty_b, 1);

        for (int i = 0; i < 16; i++) begin
            step(1, 1'b1, 32'hB0 + i, 1'b0);
            if (i == 12) chk("fwft afull 13", af_b, 0);
            if (i == 13) chk("fwft afull 14", af_b, 1);
        end
        chk("fwft full",  full_b, 1);
        chk("fwft wrcnt", 32'(wrc_b), 1);
        step(1, 1'b1, 32'hEE, 1'b0);
        chk("fwft wrerr", wrerr_b, 1);
        for (int i = 0; i < 16; i++) begin
            chk("fwft drain", dout_b, 32'hB0 + i);
            step(1, 1'b0, 0, 1'b1);
        end
        chk("fwft empty end", empty_b, 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
